// File: rtl/pwm_multi_if.sv
// pwm_multi_if: register-side update bus of the multi-channel PWM.
//   upd_i     - update request strobe (master -> slave)
//   period_i  - new period count P
//   duty_i    - new duty thresholds, channel i at [i*CNT_W +: CNT_W]
//   mode_i    - 0 = edge-aligned, 1 = center-aligned
//   pol_i     - per-channel polarity, 1 = inverted output
//   upd_ack_o - one-cycle strobe when staging lands in the active set
interface pwm_multi_if #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 32
);
    logic                 upd_i;
    logic [CNT_W-1:0]     period_i;
    logic [NCH*CNT_W-1:0] duty_i;
    logic                 mode_i;
    logic [NCH-1:0]       pol_i;
    logic                 upd_ack_o;

    modport master (
        output upd_i, period_i, duty_i, mode_i, pol_i,
        input  upd_ack_o
    );

    modport slave (
        input  upd_i, period_i, duty_i, mode_i, pol_i,
        output upd_ack_o
    );
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: NCH-channel PWM generator sharing one period counter.
// Edge- or center-aligned counting, per-channel duty and polarity,
// shadowed updates applied at period boundaries.
//   clk           - clock
//   rst           - asynchronous active-low reset
//   en            - run enable
//   bus           - update bus (slave side), see pwm_multi_if
//   pulse_o       - registered PWM outputs, one per channel
//   period_done_o - combinational strobe during the boundary cycle
module pwm_multi #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    pwm_multi_if.slave     bus,
    output logic [NCH-1:0] pulse_o,
    output logic           period_done_o
);
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic [CNT_W-1:0]            cnt, cnt_nxt;
    dir_t                        dir, dir_nxt;
    logic [CNT_W-1:0]            p_q, s_p, p_nxt;
    logic [NCH-1:0][CNT_W-1:0]   duty_q, s_duty;
    logic                        mode_q, s_mode;
    logic [NCH-1:0]              pol_q, s_pol;
    logic                        pending, ack_q;
    logic                        boundary, ld, take_in, take_stg;

    always_comb begin
        boundary = 1'b0;
        if (p_q == ONE)
            boundary = 1'b1;
        else if (p_q != '0)
            boundary = mode_q ? (dir == DIR_DOWN && cnt == '0)
                              : (cnt == p_q - ONE);
    end

    assign period_done_o = en & boundary;

    // With P_q==0 no period is running, so updates load immediately;
    // otherwise a request made after reset could never take effect.
    assign ld       = ~en | boundary | (p_q == '0);
    assign take_in  = ld & bus.upd_i;
    assign take_stg = ld & ~bus.upd_i & pending;
    assign p_nxt    = take_in ? bus.period_i : (take_stg ? s_p : p_q);

    always_comb begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        if (en && p_q > ONE) begin
            if (!mode_q) begin
                cnt_nxt = (cnt >= p_q - ONE) ? '0 : cnt + ONE;
            end else if (dir == DIR_UP) begin
                if (cnt >= p_q - ONE) begin
                    dir_nxt = DIR_DOWN;
                    cnt_nxt = cnt - ONE;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end else if (cnt == '0) begin
                // Turnaround at the boundary: step up, but stay inside
                // the period that is being loaded at this same edge.
                cnt_nxt = (p_nxt >= TWO) ? ONE : '0;
            end else begin
                dir_nxt = DIR_DOWN;
                cnt_nxt = cnt - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            dir     <= DIR_UP;
            p_q     <= '0;
            duty_q  <= '0;
            mode_q  <= 1'b0;
            pol_q   <= '0;
            s_p     <= '0;
            s_duty  <= '0;
            s_mode  <= 1'b0;
            s_pol   <= '0;
            pending <= 1'b0;
            ack_q   <= 1'b0;
            pulse_o <= '0;
        end else begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
            for (int unsigned i = 0; i < NCH; i++)
                pulse_o[i] <= (en && p_q != '0) ? ((cnt < duty_q[i]) ^ pol_q[i])
                                                : pol_q[i];
            ack_q <= take_in | take_stg;
            if (take_in) begin
                p_q    <= bus.period_i;
                duty_q <= bus.duty_i;
                mode_q <= bus.mode_i;
                pol_q  <= bus.pol_i;
            end else if (take_stg) begin
                p_q    <= s_p;
                duty_q <= s_duty;
                mode_q <= s_mode;
                pol_q  <= s_pol;
            end
            if (ld) begin
                pending <= 1'b0;
            end else if (bus.upd_i) begin
                s_p     <= bus.period_i;
                s_duty  <= bus.duty_i;
                s_mode  <= bus.mode_i;
                s_pol   <= bus.pol_i;
                pending <= 1'b1;
            end
        end
    end

    assign bus.upd_ack_o = ack_q;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi (NCH=4, CNT_W=32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pwm_multi;
    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [NCH-1:0] pulse_o;
    logic           pd;
    int unsigned    n_pass  = 0;
    int unsigned    n_total = 0;

    pwm_multi_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    pwm_multi #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .bus           (bus),
        .pulse_o       (pulse_o),
        .period_done_o (pd)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_upd(input logic [31:0] p, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input logic m, input logic [3:0] pl);
        bus.upd_i    = 1'b1;
        bus.period_i = p;
        bus.duty_i   = {d3, d2, d1, d0};
        bus.mode_i   = m;
        bus.pol_i    = pl;
    endtask

    // Load a configuration with en low, then raise en; returns at the
    // falling edge right after the load, counting begins at the next edge.
    task automatic start(input logic [31:0] p, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3,
                         input logic m, input logic [3:0] pl);
        en = 1'b0;
        set_upd(p, d0, d1, d2, d3, m, pl);
        tick();
        bus.upd_i = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b0;
        bus.upd_i = 1'b0; bus.period_i = '0; bus.duty_i = '0; bus.mode_i = 1'b0; bus.pol_i = '0;
        tick(); tick();
        n_total++; if (pulse_o !== 4'b0000) $display("FAIL reset_pulse got %b want 0000", pulse_o); else n_pass++;
        n_total++; if (pd !== 1'b0) $display("FAIL reset_pd got %b want 0", pd); else n_pass++;
        n_total++; if (bus.upd_ack_o !== 1'b0) $display("FAIL reset_ack got %b want 0", bus.upd_ack_o); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_edge;
        logic [3:0] e;
        start(5, 2, 0, 5, 3, 1'b0, 4'b0000);
        n_total++; if (bus.upd_ack_o !== 1'b1) $display("FAIL edge_ack got %b want 1", bus.upd_ack_o); else n_pass++;
        for (int k = 0; k < 10; k++) begin
            tick();
            e = {(k % 5) < 3, 1'b1, 1'b0, (k % 5) < 2};
            n_total++; if (pulse_o !== e) $display("FAIL edge_pulse k=%0d got %b want %b", k, pulse_o, e); else n_pass++;
            n_total++; if (pd !== ((k % 5) == 3)) $display("FAIL edge_pd k=%0d got %b want %b", k, pd, (k % 5) == 3); else n_pass++;
            if (k == 0) begin
                n_total++; if (bus.upd_ack_o !== 1'b0) $display("FAIL edge_ack_once got %b want 0", bus.upd_ack_o); else n_pass++;
            end
        end
    endtask

    task automatic test_center;
        int s[6] = '{0, 1, 2, 3, 2, 1};
        int v;
        logic [3:0] e;
        start(4, 1, 0, 4, 2, 1'b1, 4'b0000);
        n_total++; if (bus.upd_ack_o !== 1'b1) $display("FAIL center_ack got %b want 1", bus.upd_ack_o); else n_pass++;
        for (int k = 0; k < 12; k++) begin
            tick();
            v = s[k % 6];
            e = {v < 2, 1'b1, 1'b0, v < 1};
            n_total++; if (pulse_o !== e) $display("FAIL center_pulse k=%0d got %b want %b", k, pulse_o, e); else n_pass++;
            n_total++; if (pd !== ((k % 6) == 5)) $display("FAIL center_pd k=%0d got %b want %b", k, pd, (k % 6) == 5); else n_pass++;
        end
    endtask

    task automatic test_shadow;
        logic ep;
        start(5, 3, 0, 0, 0, 1'b0, 4'b0000);
        tick();
        n_total++; if (pulse_o[0] !== 1'b1) $display("FAIL shadow_first got %b want 1", pulse_o[0]); else n_pass++;
        set_upd(5, 1, 0, 0, 0, 1'b0, 4'b0000);
        for (int k = 1; k < 15; k++) begin
            tick();
            bus.upd_i = 1'b0;
            ep = (k < 5) ? ((k % 5) < 3) : ((k % 5) < 1);
            n_total++; if (pulse_o[0] !== ep) $display("FAIL shadow_pulse k=%0d got %b want %b", k, pulse_o[0], ep); else n_pass++;
            n_total++; if (bus.upd_ack_o !== (k == 4)) $display("FAIL shadow_ack k=%0d got %b want %b", k, bus.upd_ack_o, k == 4); else n_pass++;
        end
    endtask

    task automatic test_bounds;
        start(7, 0, 7, 0, 7, 1'b0, 4'b1100);
        for (int k = 0; k < 14; k++) begin
            tick();
            n_total++; if (pulse_o !== 4'b0110) $display("FAIL bound_pulse k=%0d got %b want 0110", k, pulse_o); else n_pass++;
            n_total++; if (pd !== ((k % 7) == 5)) $display("FAIL bound_pd k=%0d got %b want %b", k, pd, (k % 7) == 5); else n_pass++;
        end
        start(0, 3, 3, 3, 3, 1'b0, 4'b0101);
        n_total++; if (bus.upd_ack_o !== 1'b1) $display("FAIL p0_ack got %b want 1", bus.upd_ack_o); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_total++; if (pulse_o !== 4'b0101) $display("FAIL p0_pulse k=%0d got %b want 0101", k, pulse_o); else n_pass++;
            n_total++; if (pd !== 1'b0) $display("FAIL p0_pd k=%0d got %b want 0", k, pd); else n_pass++;
        end
        for (int m = 0; m < 2; m++) begin
            start(1, 1, 0, 0, 0, m[0], 4'b0000);
            for (int k = 0; k < 4; k++) begin
                tick();
                n_total++; if (pd !== 1'b1) $display("FAIL p1_pd mode=%0d k=%0d got %b want 1", m, k, pd); else n_pass++;
                n_total++; if (pulse_o !== 4'b0001) $display("FAIL p1_pulse mode=%0d k=%0d got %b want 0001", m, k, pulse_o); else n_pass++;
            end
        end
    endtask

    task automatic test_idle;
        logic [3:0] e;
        en = 1'b0;
        set_upd(5, 2, 2, 2, 2, 1'b0, 4'b1001);
        tick();
        bus.upd_i = 1'b0;
        n_total++; if (bus.upd_ack_o !== 1'b1) $display("FAIL idle_ack got %b want 1", bus.upd_ack_o); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++; if (pulse_o !== 4'b1001) $display("FAIL idle_pulse k=%0d got %b want 1001", k, pulse_o); else n_pass++;
            n_total++; if (pd !== 1'b0) $display("FAIL idle_pd k=%0d got %b want 0", k, pd); else n_pass++;
            n_total++; if (bus.upd_ack_o !== 1'b0) $display("FAIL idle_ack_low k=%0d got %b want 0", k, bus.upd_ack_o); else n_pass++;
        end
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            e = (((k % 5) < 2) ? 4'b1111 : 4'b0000) ^ 4'b1001;
            n_total++; if (pulse_o !== e) $display("FAIL idle_run k=%0d got %b want %b", k, pulse_o, e); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        logic ep;
        start(5, 2, 2, 2, 2, 1'b0, 4'b1100);
        tick();
        tick();
        set_upd(3, 1, 1, 1, 1, 1'b0, 4'b0000);
        tick();
        bus.upd_i = 1'b0;
        n_total++; if (pulse_o !== 4'b1100) $display("FAIL rmid_before got %b want 1100", pulse_o); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++; if (pulse_o !== 4'b0000) $display("FAIL rmid_async_pulse got %b want 0000", pulse_o); else n_pass++;
        n_total++; if (pd !== 1'b0) $display("FAIL rmid_async_pd got %b want 0", pd); else n_pass++;
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_total++; if (pulse_o !== 4'b0000) $display("FAIL rmid_idle_pulse k=%0d got %b want 0000", k, pulse_o); else n_pass++;
            n_total++; if (pd !== 1'b0) $display("FAIL rmid_idle_pd k=%0d got %b want 0", k, pd); else n_pass++;
            n_total++; if (bus.upd_ack_o !== 1'b0) $display("FAIL rmid_no_ack k=%0d got %b want 0", k, bus.upd_ack_o); else n_pass++;
        end
        set_upd(5, 2, 0, 0, 0, 1'b0, 4'b0000);
        tick();
        bus.upd_i = 1'b0;
        n_total++; if (bus.upd_ack_o !== 1'b1) $display("FAIL rmid_reload_ack got %b want 1", bus.upd_ack_o); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            tick();
            ep = (k % 5) < 2;
            n_total++; if (pulse_o !== {3'b000, ep}) $display("FAIL rmid_run k=%0d got %b want %b", k, pulse_o, {3'b000, ep}); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_shadow();
        test_bounds();
        test_idle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel PWM generator; generalised successor of the single-channel pulse generator.
- NCH channels share one period counter; each channel has its own duty threshold and output polarity.
- Adds edge-aligned and center-aligned modes, glitch-free shadowed updates at period boundaries, and a period-done strobe.
- Sits in the timer/peripheral area and is driven by a register front-end.

Parameters:
- NCH, 4, number of PWM channels (1..16).
- CNT_W, 32, width of the period counter and the duty values.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset.
- en  input  1  run enable.
- upd_i  input  1  update request; samples period_i, duty_i, mode_i, pol_i into staging.
- period_i  input  CNT_W  new period count P.
- duty_i  input  NCH*CNT_W  new duty thresholds; channel i at bits [i*CNT_W +: CNT_W].
- mode_i  input  1  0 = edge-aligned, 1 = center-aligned.
- pol_i  input  NCH  per-channel polarity; 1 = inverted output.
- pulse_o  output  NCH  registered PWM outputs.
- period_done_o  output  1  one-cycle strobe at each period boundary.
- upd_ack_o  output  1  one-cycle strobe when staging is loaded into the active registers.

Behaviour:
- Reset (rst=0, asynchronous) clears everything to 0: cnt, dir (up), active and staging registers, the pending flag, and all outputs.
- Update request: upd_i=1 captures the inputs into staging and sets pending. A new upd_i while pending overwrites staging (last wins).
- Staging is loaded into active (P_q, duty_q, mode_q, pol_q) at the next boundary, or on the next clk if en=0. pending then clears and upd_ack_o pulses in the following cycle.
- If upd_i coincides with a boundary (or with en=0), the incoming values load directly at that edge.
- en=0 behaviour: cnt=0, dir=up, period_done_o=0, pulse_o<=pol_q on each clk. When en rises, counting starts at cnt=0.
- Edge-aligned mode (mode_q=0), en=1:
  - cnt counts 0..P_q-1 and wraps to 0.
  - A boundary occurs in any cycle with cnt==P_q-1.
  - Effective period is P_q cycles.
- Center-aligned mode (mode_q=1), en=1:
  - In the up direction, cnt increments. At cnt==P_q-1, dir flips to down and cnt decrements.
  - In the down direction, cnt decrements. At cnt==0, a boundary occurs, dir flips to up and cnt increments.
  - Effective period is 2*(P_q-1) cycles for P_q>=2.
- Degenerate periods: P_q==0 holds cnt=0, no boundaries, and pulse_o=pol_q. P_q==1 gives a boundary every cycle with cnt=0 in both modes.
- period_done_o is combinational: en & boundary condition on the current cnt/dir.
- Output compare:
  - pulse_o[i] <= en ? ((cnt < duty_q[i]) ^ pol_q[i]) : pol_q[i].
  - Latency is one cycle from cnt value to output.
  - duty 0 means never active; duty>=P_q means always active (100%).
- Arithmetic: unsigned CNT_W-bit compares. Counter never exceeds P_q-1 and never underflows.
- Reset asserted mid-period aborts immediately: outputs go to 0 and any pending update is discarded.

Test Plan:
- Edge mode: P=5, duty0=2, pol=0, en=1 -> pulse_o[0] pattern 1,1,0,0,0 repeating with one-cycle latency; period_done_o every 5th cycle at cnt=4.
- Center mode: P=4, duty=1 -> cnt sequence 0,1,2,3,2,1,0,1...; period 6 cycles; pulse high only for the cnt=0 sample; period_done_o at cnt==0 going down.
- Shadow update: upd_i with duty 3->1 at cnt=1 -> old duty holds until the boundary; new duty applies from the next period; upd_ack_o pulses exactly once the cycle after the load.
- Boundaries: duty=0 gives constant 0; duty=P=7 gives constant 1; pol=1 inverts both; P=0 gives pulse_o=pol and no period_done_o; P=1 gives period_done_o continuously.
- Enable/idle: en=0 with upd_i -> load on the next clk and ack; when en rises, cnt starts at 0 and pulse_o=pol while idle.
- Reset mid-operation: rst low at cnt=3 with an update pending -> all outputs 0 asynchronously; after release with en=1, P_q=0 and no pulses until a new upd_i is issued.
